// File: rtl/bayer_grey_pipe.sv
// Bayer-to-greyscale converter: builds 2x2 quads from a raw CCD stream through a
// one-line buffer and emits one grey pixel per quad after a three-stage pipeline.
module bayer_grey_pipe #(
    parameter int DW     = 12,
    parameter int LINE_W = 1280,
    parameter int AW     = 11
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic [DW-1:0] iDATA,
    input  logic          iDVAL,
    input  logic [AW-1:0] iX_Cont,
    input  logic [AW-1:0] iY_Cont,
    input  logic [1:0]    iMode,
    input  logic [1:0]    iPhase,
    output logic [DW-1:0] oGrey,
    output logic          oDVAL,
    output logic [AW-2:0] oX,
    output logic [AW-2:0] oY,
    output logic          oOvf
);
    localparam int          RAW      = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [AW:0] LINE_LIM = (AW+1)'(LINE_W);

    // Returns {R, Gs, B}; a..d are the quad pixels (y-1,x-1), (y-1,x), (y,x-1), (y,x).
    function automatic logic [3*DW:0] map_phase(input logic [1:0] phase,
                                                 input logic [DW-1:0] qa, qb, qc, qd);
        logic [DW:0] g_bc;
        logic [DW:0] g_ad;
        g_bc = {1'b0, qb} + {1'b0, qc};
        g_ad = {1'b0, qa} + {1'b0, qd};
        case (phase)
            2'd0:    return {qa, g_bc, qd};
            2'd1:    return {qb, g_ad, qc};
            2'd2:    return {qc, g_ad, qb};
            default: return {qd, g_bc, qa};
        endcase
    endfunction

    // Truncating grey arithmetic; every mode's maximum fits DW bits.
    function automatic logic [DW-1:0] grey_calc(input logic [1:0] mode, input logic [DW-1:0] r,
                                                input logic [DW:0] gs, input logic [DW-1:0] b);
        logic [DW+1:0] sum_eq;
        logic [DW+3:0] sum_wt;
        sum_eq = {2'b00, r} + {1'b0, gs} + {2'b00, b};
        sum_wt = ({4'b0000, r} << 2) + ({3'b000, gs} << 2) + {3'b000, gs} + ({4'b0000, b} << 1);
        case (mode)
            2'd1:    return sum_wt[DW+3:4];
            2'd2:    return gs[DW:1];
            default: return sum_eq[DW+1:2];
        endcase
    endfunction

    logic accept;
    logic ovf_now;
    logic frame_start;
    logic prev_ok;
    logic [1:0] mode_cfg;
    logic [1:0] phase_cfg;

    assign accept      = iDVAL && ({1'b0, iX_Cont} < LINE_LIM);
    assign ovf_now     = iDVAL && !({1'b0, iX_Cont} < LINE_LIM);
    assign frame_start = accept && (iX_Cont == '0) && (iY_Cont == '0);

    // Stage 0: input register, configuration latch, row-valid guard, overflow flag
    logic           acc_p0;
    logic           quad_p0;
    logic [DW-1:0]  data_p0;
    logic [RAW-1:0] addr_p0;
    logic [AW-2:0]  ox_p0;
    logic [AW-2:0]  oy_p0;
    logic [1:0]     mode_p0;
    logic [1:0]     phase_p0;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            acc_p0    <= 1'b0;
            quad_p0   <= 1'b0;
            mode_cfg  <= 2'd0;
            phase_cfg <= 2'd0;
            prev_ok   <= 1'b0;
            oOvf      <= 1'b0;
        end else begin
            acc_p0  <= accept;
            quad_p0 <= accept && iY_Cont[0] && iX_Cont[0] && prev_ok;
            if (frame_start) begin
                mode_cfg  <= iMode;
                phase_cfg <= iPhase;
            end
            if (accept && !iY_Cont[0])
                prev_ok <= 1'b1;
            if (ovf_now)
                oOvf <= 1'b1;
            else if (frame_start)
                oOvf <= 1'b0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (accept) begin
            data_p0  <= iDATA;
            addr_p0  <= iX_Cont[RAW-1:0];
            ox_p0    <= iX_Cont[AW-1:1];
            oy_p0    <= iY_Cont[AW-1:1];
            mode_p0  <= frame_start ? iMode : mode_cfg;
            phase_p0 <= frame_start ? iPhase : phase_cfg;
        end
    end

    // Stage 1: line-buffer read-before-write and gap-tolerant delay taps
    logic [DW-1:0] line_ram [LINE_W];
    logic [DW-1:0] prev_p1;
    logic [DW-1:0] cur_p1;
    logic [DW-1:0] prev_d;
    logic [DW-1:0] cur_d;
    logic          vld_p1;
    logic [AW-2:0] ox_p1;
    logic [AW-2:0] oy_p1;
    logic [1:0]    mode_p1;
    logic [1:0]    phase_p1;

    always_ff @(posedge iCLK) begin
        if (acc_p0) begin
            prev_p1           <= line_ram[addr_p0];
            line_ram[addr_p0] <= data_p0;
            ox_p1             <= ox_p0;
            oy_p1             <= oy_p0;
            mode_p1           <= mode_p0;
            phase_p1          <= phase_p0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            vld_p1 <= 1'b0;
            cur_p1 <= '0;
            cur_d  <= '0;
            prev_d <= '0;
        end else begin
            vld_p1 <= quad_p0;
            if (acc_p0) begin
                cur_p1 <= data_p0;
                cur_d  <= cur_p1;
                prev_d <= prev_p1;
            end
        end
    end

    // Stage 2: phase mapping to R / Gs / B
    logic          vld_p2;
    logic [DW-1:0] r_p2;
    logic [DW:0]   gs_p2;
    logic [DW-1:0] b_p2;
    logic [AW-2:0] ox_p2;
    logic [AW-2:0] oy_p2;
    logic [1:0]    mode_p2;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST)
            vld_p2 <= 1'b0;
        else
            vld_p2 <= vld_p1;
    end

    always_ff @(posedge iCLK) begin
        if (vld_p1) begin
            {r_p2, gs_p2, b_p2} <= map_phase(phase_p1, prev_d, prev_p1, cur_d, cur_p1);
            ox_p2   <= ox_p1;
            oy_p2   <= oy_p1;
            mode_p2 <= mode_p1;
        end
    end

    // Stage 3: mode arithmetic into the output registers
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oDVAL <= 1'b0;
            oGrey <= '0;
            oX    <= '0;
            oY    <= '0;
        end else begin
            oDVAL <= vld_p2;
            if (vld_p2) begin
                oGrey <= grey_calc(mode_p2, r_p2, gs_p2, b_p2);
                oX    <= ox_p2;
                oY    <= oy_p2;
            end
        end
    end
endmodule

// File: doc/bayer_grey_pipe.md
# bayer_grey_pipe

Parametrised Bayer-to-greyscale converter: takes the raw CCD pixel stream, forms 2x2 Bayer quads with an internal one-line buffer, and emits one grey pixel per quad (half resolution in X and Y). It sits between the CCD capture stage and the frame-buffer/filter stages. Over the previous converter it adds:

- configurable pixel width and line length;
- runtime-selectable Bayer phase;
- three grey modes;
- gap-tolerant delay taps;
- output coordinates;
- an overflow flag.

## Interface
- DW, 12 — raw and grey pixel width
- LINE_W, 1280 — max pixels per line; line-buffer depth
- AW, 11 — width of iX_Cont/iY_Cont
- iCLK  in  1  sole clock, rising edge
- iRST  in  1  asynchronous, active-low reset
- iDATA  in  DW  raw Bayer pixel
- iDVAL  in  1  iDATA valid this cycle
- iX_Cont  in  AW  column of iDATA
- iY_Cont  in  AW  row of iDATA
- iMode  in  2  0 = equal average, 1 = luma-weighted, 2 = green only, 3 = same as 0
- iPhase  in  2  colour at (even row, even col): 0 = RGGB, 1 = GRBG, 2 = GBRG, 3 = BGGR
- oGrey  out  DW  grey result
- oDVAL  out  1  oGrey valid, single-cycle strobe per quad
- oX  out  AW-1  output column = iX_Cont>>1 of the emitting pixel
- oY  out  AW-1  output row = iY_Cont>>1
- oOvf  out  1  sticky: a valid pixel arrived with iX_Cont >= LINE_W

## Operation
- **Accepted pixel:** iDVAL=1 and iX_Cont < LINE_W. A valid pixel with iX_Cont >= LINE_W is dropped: no buffer write, no output, oOvf set.
- **Line buffer:**
  - LINE_W x DW synchronous RAM addressed by iX_Cont.
  - Each accepted pixel reads the old word (pixel of the previous row, same column), then writes iDATA in the same cycle (read-before-write).
- **Delay taps:** cur_d and prev_d hold the previous *accepted* pixel and its buffer word. They update only on accepted pixels, so iDVAL gaps do not corrupt the quad.
- **Quad:** formed when an accepted pixel has iY_Cont[0]=1 and iX_Cont[0]=1.
  - a = prev_d (y-1, x-1)
  - b = prev (y-1, x)
  - c = cur_d (y, x-1)
  - d = cur (y, x)
- **Phase mapping** (Gs = G1+G2, DW+1 bits):
  - RGGB: R=a, Gs=b+c, B=d
  - GRBG: R=b, Gs=a+d, B=c
  - GBRG: R=c, Gs=a+d, B=b
  - BGGR: R=d, Gs=b+c, B=a
- **Modes** (all truncating, no rounding; result always fits DW, no saturation needed):
  - 0/3: (R + Gs + B) >> 2, computed in DW+2 bits
  - 1: (4R + 5Gs + 2B) >> 4, computed in DW+4 bits
  - 2: Gs >> 1
- **Configuration latch:**
  - iMode and iPhase are captured into internal registers on an accepted pixel with iX_Cont=0 and iY_Cont=0 (frame start); that pixel already uses the new values.
  - Changes mid-frame have no effect until the next frame start.
  - Registers reset to 0.
- **oOvf:** set on overflow; cleared on reset and at frame start. If both occur in the same cycle, set wins.
- **Row-valid guard:**
  - prev_ok clears on reset and sets on any accepted pixel with iY_Cont[0]=0.
  - Quads formed while prev_ok=0 produce no oDVAL. This guarantees no output uses buffer contents from before reset.
- Pixels on even rows or even columns never produce output.

## Timing
- 3-stage pipeline:
  - S1: input register + RAM read
  - S2: phase mapping to R/Gs/B
  - S3: mode arithmetic into output registers
- oDVAL rises exactly 3 cycles after the iCLK edge sampling the quad-completing pixel, for one cycle. oGrey, oX and oY are valid in the same cycle.
- Between strobes, oGrey/oX/oY hold their last values.
- Throughput: one input pixel per cycle sustained; iDVAL gaps of any length are allowed.
- Reset (async assert, sync release) clears:
  - oGrey, oX, oY, oDVAL, oOvf;
  - all pipeline valids, taps and prev_ok.
- RAM contents are not cleared. A reset mid-frame flushes in-flight quads with no oDVAL.

## Test plan
- **RGGB phase, mode 0:** phase 0, rows 0/1 carry a=100, b=200, c=300, d=400 at x=0..1 → oGrey=250, oX=0, oY=0, exactly 3 cycles after d. Mode 1 → 231; mode 2 → 250.
- **BGGR phase:** phase 3, same data → mode 0: 250; mode 1: 268. Changing iPhase mid-frame gives no change until the next (0,0) pixel.
- **iDVAL gaps:** same quad with 5 idle cycles between c and d → identical result. Confirm no oDVAL while iDVAL=0.
- **Full frame:** 8x4 frame, LINE_W=8, pixel value = x + 16y → exactly 8 strobes, correct oX/oY ordering, per-quad values match a model.
- **Overflow:** pixel at iX_Cont=LINE_W → oOvf=1, no buffer write, no strobe; the next frame start clears oOvf.
- **Reset mid-operation:** assert iRST during row 1 → all outputs 0 immediately. Resuming on row 3 gives no strobe until a row-even pixel is accepted; strobes resume on row 5.
